data_serializer: RTL and testbench
==================================

# data_serializer

Parallel-to-serial converter: accepts a 16-bit word with a valid-bit count and shifts it out MSB-first, one bit per clock, with a per-bit valid strobe. Sits between a word-oriented producer and a single-wire bit consumer. Producer flow control uses `busy_o`; words offered while busy are dropped.

## Interface
- `DATA_W`, 16: parallel word width.
- `MOD_W`, 4: width of the bit-count field, equal to $clog2(DATA_W).
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `srst_i`  in  1  reset, synchronous and active-high.
- `data_i`  in  DATA_W  word to serialize; bit DATA_W-1 is sent first.
- `data_mod_i`  in  MOD_W  number of valid bits counted from the MSB; 0 means all DATA_W bits.
- `data_val_i`  in  1  `data_i`/`data_mod_i` valid this cycle.
- `ser_data_o`  out  1  serial data bit.
- `ser_data_val_o`  out  1  `ser_data_o` is valid this cycle.
- `busy_o`  out  1  a transfer is in progress; new words are ignored.

## Operation
- Accept condition: `data_val_i`=1 and `busy_o`=0 at a rising edge. `data_i` is captured into a shift register; the length is N = (`data_mod_i`==0 ? DATA_W : `data_mod_i`).
- N = 1 or 2: the word is rejected. No state change occurs, and `busy_o` and `ser_data_val_o` stay 0.
- States: IDLE and SHIFT.
  - IDLE -> SHIFT on an accepted word with N ≥ 3.
  - SHIFT -> IDLE after the N-th bit has been presented.
- In SHIFT, each cycle presents bits data_i[DATA_W-1], data_i[DATA_W-2], …, data_i[DATA_W-N] in order.
- The bit counter is MOD_W+1 bits wide so that N=16 is represented without wrap.
- `data_val_i` during SHIFT is ignored, including on the last bit cycle. Its data is not queued.
- `ser_data_o` is driven 0 whenever `ser_data_val_o`=0.
- Bits below position DATA_W-N are never output.

## Timing
- All outputs are registered.
- Reset value of every output is 0; the state returns to IDLE and the counter clears.
- Accept at edge k: from edge k, `ser_data_val_o`=1, `busy_o`=1 and `ser_data_o`=data_i[DATA_W-1].
- Bit i (0-based) is valid for the cycle following edge k+i.
- At edge k+N, `busy_o`, `ser_data_val_o` and `ser_data_o` return to 0.
- Latency from accept to the first valid bit is 1 cycle (registered). `busy_o` is high for exactly N cycles.
- Minimum spacing between accepted words is N+1 cycles. `data_val_i` held high continuously re-accepts on the first cycle `busy_o` is 0.
- `srst_i` asserted mid-transfer aborts the transfer at that edge: outputs are 0 on the next cycle and the partial word is discarded.
- If reset and `data_val_i` are high together, reset wins.

## Configuration
- `DATA_SERIALIZER_SVA_EN` defined: the module compiles in concurrent assertions.
  - `ser_data_val_o` implies `busy_o`.
  - `ser_data_o`==0 when not valid.
  - `busy_o` never high for more than DATA_W consecutive cycles.
  - All outputs are 0 the cycle after `srst_i`.
- Not defined: the assertions are absent; RTL behaviour is identical.

## Structure
- Package `data_serializer_pkg` holds:
  - `DATA_W` and `MOD_W` defaults.
  - The state enum `ser_state_t` {IDLE, SHIFT}.
  - Constant `MIN_LEN`=3.
- Single module `data_serializer`; no sub-module. It contains the shift register, the bit counter and the two-state FSM.

## Test plan
- Word 16'b1111_0000_1111_0000 with mod=0, one-cycle `data_val_i` → 16 valid cycles carrying 1111000011110000 MSB-first with `busy_o`=1, then one cycle of all outputs 0 (18 checked cycles total).
- Word 16'hA5FF with mod=3 → 3 valid cycles with bits 1,0,1, `busy_o` high for 3 cycles, then idle.
- Words with mod=1 and mod=2 → `busy_o`, `ser_data_val_o` and `ser_data_o` stay 0 throughout.
- Accept 16'hFFFF (mod=0), then assert `data_val_i` with 16'h0000 on cycles 5 and 16 of the transfer → 16 ones are sent, the second word is ignored, and `busy_o` falls after 16 cycles.
- `srst_i` pulsed on the 7th bit of a 16-bit transfer → all outputs 0 from the next cycle. A new word accepted afterwards starts from its own MSB.
- `data_val_i` held high with 16'hC000, mod=4 → transfers of 1,1,0,0 repeat with exactly one idle cycle between them.

Source files
------------

// File: rtl/data_serializer_pkg.sv
// Shared widths, state encoding and word-length helper for the data_serializer block.
// The optional assertion set is enabled by defining DATA_SERIALIZER_SVA_EN.
package data_serializer_pkg;

  localparam int DATA_W  = 16;
  localparam int MOD_W   = 4;
  localparam int MIN_LEN = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // A bit-count field of zero stands for a full DATA_W-bit word.
  function automatic logic [MOD_W:0] word_len(input logic [MOD_W-1:0] mod);
    return (mod == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, mod};
  endfunction

endpackage

// File: rtl/data_serializer_if.sv
// Word-in / bit-out bundle between a word producer, the serializer and a serial consumer.
// Assertions in the serializer are enabled by DATA_SERIALIZER_SVA_EN; this file has none.
interface data_serializer_if;
  import data_serializer_pkg::*;

  // Handshake: the producer presents data_i/data_mod_i with data_val_i high for a cycle.
  // The word is taken only if busy_o is low at that rising edge; otherwise it is dropped,
  // never queued. ser_data_o carries meaning only while ser_data_val_o is high.
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  modport master (
    output data_i, data_mod_i, data_val_i,
    input  ser_data_o, ser_data_val_o, busy_o
  );

  modport slave (
    input  data_i, data_mod_i, data_val_i,
    output ser_data_o, ser_data_val_o, busy_o
  );

endinterface

// File: rtl/data_serializer.sv
// Parallel-to-serial converter: shifts an accepted word out MSB-first, one bit per clock.
// Define DATA_SERIALIZER_SVA_EN to compile in the output-protocol assertions.
module data_serializer
  import data_serializer_pkg::*;
(
  input  logic              clk_i,
  input  logic              srst_i,
  data_serializer_if.slave  bus,
  output ser_state_t        state_o
);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [MOD_W:0]    cnt_q, cnt_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_val_q, ser_val_d;
  logic              busy_q, busy_d;
  logic [MOD_W:0]    len;

  assign len = word_len(bus.data_mod_i);

  // The first bit is loaded on the accept edge, so cnt holds the bits still to come.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ser_data_d = 1'b0;
    ser_val_d  = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_val_i && (len >= (MOD_W+1)'(MIN_LEN))) begin
          state_d    = SHIFT;
          shift_d    = bus.data_i << 1;
          cnt_d      = len - 1'b1;
          ser_data_d = bus.data_i[DATA_W-1];
          ser_val_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          shift_d    = shift_q << 1;
          cnt_d      = cnt_q - 1'b1;
          ser_data_d = shift_q[DATA_W-1];
          ser_val_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ser_data_q <= ser_data_d;
      ser_val_q  <= ser_val_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ser_data_o     = ser_data_q;
  assign bus.ser_data_val_o = ser_val_q;
  assign bus.busy_o         = busy_q;
  assign state_o            = state_q;

`ifdef DATA_SERIALIZER_SVA_EN
  // Number of busy cycles already completed in the current busy run.
  logic [MOD_W+1:0] busy_run_q;

  always_ff @(posedge clk_i) begin
    if (srst_i || !busy_q) begin
      busy_run_q <= '0;
    end else if (busy_run_q != '1) begin
      busy_run_q <= busy_run_q + 1'b1;
    end
  end

  a_val_implies_busy: assert property (@(posedge clk_i) ser_val_q |-> busy_q);
  a_data_zero_idle:   assert property (@(posedge clk_i) !ser_val_q |-> !ser_data_q);
  a_busy_bounded:     assert property (@(posedge clk_i) busy_q |-> (busy_run_q < (MOD_W+2)'(DATA_W)));
  a_reset_clears:     assert property (@(posedge clk_i)
                        srst_i |=> (!busy_q && !ser_val_q && !ser_data_q));
`else
  // Assertions compiled out; datapath and FSM are unchanged.
`endif

endmodule

// File: tb/tb_data_serializer.sv
// Self-checking bench for data_serializer: per-cycle expected output samples are queued
// when stimulus is planned and popped/compared after every rising edge.
module tb_data_serializer;
  import data_serializer_pkg::*;

  localparam int W = 3;  // sample = {busy_o, ser_data_val_o, ser_data_o}

  logic       clk = 1'b0;
  logic       srst;
  ser_state_t state;

  data_serializer_if bus ();

  data_serializer dut (
    .clk_i   (clk),
    .srst_i  (srst),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int bench_len(input logic [3:0] mod);
    return (mod == 4'd0) ? 16 : int'(mod);
  endfunction

  task automatic push_bits(input logic [15:0] data, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back({2'b11, data[15-j]});
  endtask

  task automatic push_word(input logic [15:0] data, input logic [3:0] mod);
    int n;
    n = bench_len(mod);
    if (n >= 3) push_bits(data, n);
  endtask

  task automatic push_idle(input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(3'b000);
  endtask

  // Drive one cycle of inputs, clock it, then check the registered outputs.
  task automatic run_cycle(input string tag, input logic val, input logic [15:0] data,
                           input logic [3:0] mod, input logic rst);
    logic [W-1:0] exp;
    bus.data_val_i = val;
    bus.data_i     = data;
    bus.data_mod_i = mod;
    srst           = rst;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: got a cycle with no expected sample queued", tag);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, {bus.busy_o, bus.ser_data_val_o, bus.ser_data_o}, exp);
      check_eq({tag, "_state"}, {2'b00, state == SHIFT}, {2'b00, exp[2]});
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int j = 0; j < n; j++) run_cycle(tag, 1'b0, 16'h0000, 4'd0, 1'b0);
  endtask

  initial begin
    logic [15:0] rdata;
    logic [3:0]  rmod;
    int          rn;

    bus.data_val_i = 1'b0;
    bus.data_i     = '0;
    bus.data_mod_i = '0;
    srst           = 1'b1;

    // Reset state, then one cycle out of reset with nothing offered.
    push_idle(3);
    run_cycle("reset0", 1'b0, 16'h0000, 4'd0, 1'b1);
    run_cycle("reset1", 1'b0, 16'h0000, 4'd0, 1'b1);
    run_cycle("post_reset", 1'b0, 16'h0000, 4'd0, 1'b0);

    // Full 16-bit word, one-cycle valid.
    push_idle(1);
    push_word(16'b1111_0000_1111_0000, 4'd0);
    push_idle(1);
    idle_cycles("f0f0_pre", 1);
    run_cycle("f0f0", 1'b1, 16'b1111_0000_1111_0000, 4'd0, 1'b0);
    idle_cycles("f0f0", 16);

    // Minimum legal length.
    push_word(16'hA5FF, 4'd3);
    push_idle(2);
    run_cycle("mod3", 1'b1, 16'hA5FF, 4'd3, 1'b0);
    idle_cycles("mod3", 4);

    // Lengths 1 and 2 are rejected.
    push_idle(6);
    run_cycle("mod1", 1'b1, 16'hFFFF, 4'd1, 1'b0);
    idle_cycles("mod1", 2);
    run_cycle("mod2", 1'b1, 16'hFFFF, 4'd2, 1'b0);
    idle_cycles("mod2", 2);

    // Words offered while busy (transfer cycles 5 and 16) are dropped.
    push_word(16'hFFFF, 4'd0);
    push_idle(2);
    run_cycle("busy_drop", 1'b1, 16'hFFFF, 4'd0, 1'b0);
    for (int i = 1; i <= 17; i++)
      run_cycle("busy_drop", (i == 5) || (i == 16), 16'h0000, 4'd0, 1'b0);

    // Reset on the 7th bit aborts; reset beats a simultaneous valid; next word starts clean.
    push_bits(16'hBEEF, 7);
    push_idle(2);
    run_cycle("abort", 1'b1, 16'hBEEF, 4'd0, 1'b0);
    idle_cycles("abort", 6);
    run_cycle("abort_rst", 1'b0, 16'h0000, 4'd0, 1'b1);
    idle_cycles("abort_after", 1);
    push_idle(2);
    run_cycle("rst_vs_val", 1'b1, 16'hFFFF, 4'd0, 1'b1);
    idle_cycles("rst_vs_val", 1);
    push_word(16'h5A5A, 4'd5);
    push_idle(1);
    run_cycle("restart", 1'b1, 16'h5A5A, 4'd5, 1'b0);
    idle_cycles("restart", 5);

    // Continuous valid re-accepts after exactly one idle cycle.
    for (int p = 0; p < 3; p++) begin
      push_word(16'hC000, 4'd4);
      push_idle(1);
    end
    push_idle(1);
    for (int i = 0; i < 15; i++) run_cycle("hold_val", 1'b1, 16'hC000, 4'd4, 1'b0);
    idle_cycles("hold_val", 1);

    // Random words and lengths.
    for (int r = 0; r < 8; r++) begin
      rdata = 16'($urandom_range(0, 65535));
      rmod  = 4'($urandom_range(0, 15));
      rn    = bench_len(rmod);
      if (rn >= 3) begin
        push_word(rdata, rmod);
        push_idle(1);
        run_cycle("rand", 1'b1, rdata, rmod, 1'b0);
        idle_cycles("rand", rn);
      end else begin
        push_idle(2);
        run_cycle("rand_rej", 1'b1, rdata, rmod, 1'b0);
        idle_cycles("rand_rej", 1);
      end
    end

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL leftover: got %0d unchecked samples expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
